// File: rtl/vga_mode_ctrl.sv
// vga_mode_ctrl: applies requested video modes to the blanking generator only on
// frame boundaries, and forces blanking while sync is missing or new timing settles.
// Optional feature: define VGA_MODE_CTRL_DEBOUNCE_EN to filter the mode request through
// a stability debouncer (DEBOUNCE_CYCLES); the default build uses the raw request.
module vga_mode_ctrl #(
    parameter int unsigned SETTLE_FRAMES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1048575
`ifdef VGA_MODE_CTRL_DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CYCLES = 1024
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_start,
    input  logic       ds80_req,
    input  logic [1:0] screen_mode_req,
    output logic       ds80,
    output logic [1:0] screen_mode,
    output logic       force_blank,
    output logic       locked,
    output logic       mode_changed
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned FW = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;

    typedef enum logic [1:0] {StNoSync, StSettle, StRun, StPending} state_e;

    state_e          state_q, state_d;
    logic [2:0]      act_q, act_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [TW-1:0]   to_cnt_q;
    logic            prev_pix_start_q;
    logic            force_blank_q, force_blank_d;
    logic            locked_q, locked_d;
    logic            mode_changed_q, mode_changed_d;
    logic [2:0]      req;
    logic            fs;
    logic            to;

    assign fs = pix_start & ~prev_pix_start_q;
    // A frame start on the same cycle as expiry keeps sync alive.
    assign to = (to_cnt_q == TW'(TIMEOUT_CYCLES)) & ~fs;

`ifdef VGA_MODE_CTRL_DEBOUNCE_EN
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [2:0]    raw;
    logic [2:0]    raw_q;
    logic [2:0]    req_q;
    logic [DW-1:0] stab_q;

    assign raw = {ds80_req, screen_mode_req};

    // Request debouncer: copy the input only once it has held still long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            raw_q  <= 3'b000;
            req_q  <= 3'b000;
            stab_q <= '0;
        end else begin
            raw_q <= raw;
            if (raw != raw_q) begin
                stab_q <= '0;
            end else if (stab_q != DW'(DEBOUNCE_CYCLES)) begin
                stab_q <= stab_q + 1'b1;
            end
            if (stab_q == DW'(DEBOUNCE_CYCLES)) begin
                req_q <= raw_q;
            end
        end
    end

    assign req = req_q;
`else
    assign req = {ds80_req, screen_mode_req};
`endif

    // Frame-edge detector and saturating sync-loss timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pix_start_q <= 1'b0;
            to_cnt_q         <= '0;
        end else begin
            prev_pix_start_q <= pix_start;
            if (fs) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != TW'(TIMEOUT_CYCLES)) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

    // State register together with the registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StNoSync;
            act_q          <= 3'b000;
            frame_cnt_q    <= '0;
            force_blank_q  <= 1'b1;
            locked_q       <= 1'b0;
            mode_changed_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            act_q          <= act_d;
            frame_cnt_q    <= frame_cnt_d;
            force_blank_q  <= force_blank_d;
            locked_q       <= locked_d;
            mode_changed_q <= mode_changed_d;
        end
    end

    // Next-state logic; the applied mode only moves on a frame start.
    always_comb begin
        state_d        = state_q;
        act_d          = act_q;
        frame_cnt_d    = frame_cnt_q;
        mode_changed_d = 1'b0;
        unique case (state_q)
            StNoSync: begin
                if (fs) begin
                    act_d          = req;
                    mode_changed_d = (req != act_q);
                    frame_cnt_d    = '0;
                    state_d        = StSettle;
                end
            end
            StSettle: begin
                if (fs) begin
                    if (req != act_q) begin
                        act_d          = req;
                        mode_changed_d = 1'b1;
                        frame_cnt_d    = '0;
                    end else if (frame_cnt_q == FW'(SETTLE_FRAMES - 1)) begin
                        state_d = StRun;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end else if (to) begin
                    state_d = StNoSync;
                end
            end
            StRun: begin
                if (to) begin
                    state_d = StNoSync;
                end else if (req != act_q) begin
                    state_d = StPending;
                end
            end
            StPending: begin
                if (fs) begin
                    if (req != act_q) begin
                        act_d          = req;
                        mode_changed_d = 1'b1;
                        frame_cnt_d    = '0;
                        state_d        = StSettle;
                    end else begin
                        state_d = StRun;
                    end
                end else if (to) begin
                    state_d = StNoSync;
                end else if (req == act_q) begin
                    state_d = StRun;
                end
            end
            default: state_d = StNoSync;
        endcase
    end

    // Blank/lock decoded from next state so they line up with the state register.
    always_comb begin
        force_blank_d = 1'b1;
        locked_d      = 1'b0;
        if (state_d == StRun || state_d == StPending) begin
            force_blank_d = 1'b0;
            locked_d      = 1'b1;
        end
    end

    assign ds80         = act_q[2];
    assign screen_mode  = act_q[1:0];
    assign force_blank  = force_blank_q;
    assign locked       = locked_q;
    assign mode_changed = mode_changed_q;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Bench for vga_mode_ctrl: short frames and a short sync timeout, a scoreboard of
// expected applied modes consumed on each mode_changed pulse.
module tb_vga_mode_ctrl;

    localparam int unsigned PERIOD  = 100;
    localparam int unsigned HIGH    = 10;
    localparam int unsigned TO_CYC  = 300;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_start = 1'b0;
    logic       ds80_req = 1'b0;
    logic [1:0] screen_mode_req = 2'b00;
    logic       ds80;
    logic [1:0] screen_mode;
    logic       force_blank;
    logic       locked;
    logic       mode_changed;

    int         errors = 0;
    int         checks = 0;
    int         fs_count = 0;
    int         phase = PERIOD - 1;
    bit         pix_run = 1'b0;
    logic [2:0] sb[$];
    logic [2:0] exp_act;

    vga_mode_ctrl #(
        .SETTLE_FRAMES  (2),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pix_start       (pix_start),
        .ds80_req        (ds80_req),
        .screen_mode_req (screen_mode_req),
        .ds80            (ds80),
        .screen_mode     (screen_mode),
        .force_blank     (force_blank),
        .locked          (locked),
        .mode_changed    (mode_changed)
    );

    always #5 clk = ~clk;

    // Frame source: pix_start high for HIGH clks at the start of every PERIOD.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pix_run) begin
                phase = (phase == int'(PERIOD) - 1) ? 0 : phase + 1;
                pix_start = (phase < int'(HIGH));
                if (phase == 0) fs_count++;
            end else begin
                pix_start = 1'b0;
                phase = PERIOD - 1;
            end
        end
    end

    // Scoreboard: every mode_changed pulse must match the next expected applied mode.
    always @(negedge clk) begin
        if (mode_changed) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: mode_changed with act=%b, no change expected",
                         {ds80, screen_mode});
            end else begin
                exp_act = sb.pop_front();
                if ({ds80, screen_mode} !== exp_act) begin
                    errors++;
                    $display("FAIL pulse_act: act=%b expected %b", {ds80, screen_mode}, exp_act);
                end
            end
        end
    end

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // Returns at the negedge after the DUT has registered the next frame start.
    task automatic wait_fs();
        int start;
        int n;
        start = fs_count;
        n = 0;
        while (fs_count == start && n < 4 * int'(PERIOD)) begin
            @(negedge clk);
            n++;
        end
        if (fs_count == start) begin
            checks++;
            errors++;
            $display("FAIL wait_fs: no frame start within %0d clks", n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ds80, screen_mode, force_blank, locked, mode_changed} !== 6'b000_1_0_0) begin
            errors++;
            $display("FAIL reset_state: got %b expected 000100",
                     {ds80, screen_mode, force_blank, locked, mode_changed});
        end
    endtask

    task automatic test_lock();
        reset = 1'b0;
        pix_run = 1'b1;
        wait_fs();
        checks++;
        if (force_blank !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_fs1: fb=%b lk=%b expected fb=1 lk=0", force_blank, locked);
        end
        wait_fs();
        checks++;
        if (force_blank !== 1'b1) begin
            errors++;
            $display("FAIL lock_fs2: fb=%b expected 1", force_blank);
        end
        wait_fs();
        checks++;
        if (force_blank !== 1'b0 || locked !== 1'b1 || {ds80, screen_mode} !== 3'b000) begin
            errors++;
            $display("FAIL lock_fs3: fb=%b lk=%b act=%b expected fb=0 lk=1 act=000",
                     force_blank, locked, {ds80, screen_mode});
        end
    endtask

    task automatic test_mode_change();
        repeat (20) @(negedge clk);
        ds80_req = 1'b1;
        sb.push_back(3'b100);
        repeat (2) @(negedge clk);
        checks++;
        if (ds80 !== 1'b0 || locked !== 1'b1 || force_blank !== 1'b0) begin
            errors++;
            $display("FAIL pending_hold: ds80=%b lk=%b fb=%b expected 0 1 0",
                     ds80, locked, force_blank);
        end
        wait_fs();
        checks++;
        if (ds80 !== 1'b1 || force_blank !== 1'b1 || locked !== 1'b0 || mode_changed !== 1'b1) begin
            errors++;
            $display("FAIL apply_fs: ds80=%b fb=%b lk=%b mc=%b expected 1 1 0 1",
                     ds80, force_blank, locked, mode_changed);
        end
        @(negedge clk);
        checks++;
        if (mode_changed !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: mc=%b expected 0", mode_changed);
        end
        wait_fs();
        checks++;
        if (force_blank !== 1'b1) begin
            errors++;
            $display("FAIL settle_blank: fb=%b expected 1", force_blank);
        end
        wait_fs();
        checks++;
        if (locked !== 1'b1 || force_blank !== 1'b0) begin
            errors++;
            $display("FAIL relock: lk=%b fb=%b expected 1 0", locked, force_blank);
        end
    endtask

    task automatic test_cancel();
        repeat (20) @(negedge clk);
        screen_mode_req = 2'b01;
        repeat (2) @(negedge clk);
        checks++;
        if (locked !== 1'b1 || force_blank !== 1'b0 || screen_mode !== 2'b00) begin
            errors++;
            $display("FAIL cancel_pending: lk=%b fb=%b sm=%b expected 1 0 00",
                     locked, force_blank, screen_mode);
        end
        screen_mode_req = 2'b00;
        repeat (2) @(negedge clk);
        wait_fs();
        checks++;
        if (locked !== 1'b1 || force_blank !== 1'b0 || {ds80, screen_mode} !== 3'b100 ||
            mode_changed !== 1'b0) begin
            errors++;
            $display("FAIL cancel_fs: lk=%b fb=%b act=%b mc=%b expected 1 0 100 0",
                     locked, force_blank, {ds80, screen_mode}, mode_changed);
        end
    endtask

    task automatic test_timeout();
        int n;
        wait_fs();
        pix_run = 1'b0;
        n = 0;
        while (force_blank !== 1'b1 && n < int'(TO_CYC) + 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != int'(TO_CYC) + 1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL timeout: blank after %0d clks lk=%b, expected %0d clks lk=0",
                     n, locked, TO_CYC + 1);
        end
        pix_run = 1'b1;
        wait_fs();
        checks++;
        if (force_blank !== 1'b1 || {ds80, screen_mode} !== 3'b100) begin
            errors++;
            $display("FAIL resync_fs1: fb=%b act=%b expected 1 100",
                     force_blank, {ds80, screen_mode});
        end
        wait_fs();
        wait_fs();
        checks++;
        if (locked !== 1'b1 || force_blank !== 1'b0) begin
            errors++;
            $display("FAIL resync_lock: lk=%b fb=%b expected 1 0", locked, force_blank);
        end
    endtask

    task automatic test_settle_change();
        repeat (20) @(negedge clk);
        screen_mode_req = 2'b01;
        sb.push_back(3'b101);
        wait_fs();
        checks++;
        if ({ds80, screen_mode} !== 3'b101 || force_blank !== 1'b1) begin
            errors++;
            $display("FAIL settle_load1: act=%b fb=%b expected 101 1",
                     {ds80, screen_mode}, force_blank);
        end
        ds80_req = 1'b0;
        sb.push_back(3'b001);
        wait_fs();
        checks++;
        if ({ds80, screen_mode} !== 3'b001 || force_blank !== 1'b1) begin
            errors++;
            $display("FAIL settle_reload: act=%b fb=%b expected 001 1",
                     {ds80, screen_mode}, force_blank);
        end
        wait_fs();
        checks++;
        if (force_blank !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL settle_restart: fb=%b lk=%b expected 1 0", force_blank, locked);
        end
        wait_fs();
        checks++;
        if (locked !== 1'b1 || force_blank !== 1'b0) begin
            errors++;
            $display("FAIL settle_lock: lk=%b fb=%b expected 1 0", locked, force_blank);
        end
    endtask

    task automatic test_reset_mid();
        repeat (20) @(negedge clk);
        ds80_req = 1'b1;
        screen_mode_req = 2'b10;
        sb.push_back(3'b110);
        wait_fs();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ds80, screen_mode, force_blank, locked, mode_changed} !== 6'b000_1_0_0) begin
            errors++;
            $display("FAIL reset_mid: got %b expected 000100",
                     {ds80, screen_mode, force_blank, locked, mode_changed});
        end
        // Leaving reset with act=000 and req=110 reloads on the next frame start.
        sb.push_back(3'b110);
        reset = 1'b0;
        wait_fs();
        checks++;
        if ({ds80, screen_mode} !== 3'b110 || force_blank !== 1'b1) begin
            errors++;
            $display("FAIL reset_reload: act=%b fb=%b expected 110 1",
                     {ds80, screen_mode}, force_blank);
        end
    endtask

`ifdef VGA_MODE_CTRL_DEBOUNCE_EN
    task automatic test_debounce();
        for (int i = 0; i < 6; i++) begin
            ds80_req = ~ds80_req;
            repeat (500) @(negedge clk);
        end
        checks++;
        if ({ds80, screen_mode} !== 3'b000 || locked !== 1'b1) begin
            errors++;
            $display("FAIL debounce_toggle: act=%b lk=%b expected 000 1",
                     {ds80, screen_mode}, locked);
        end
        ds80_req = 1'b1;
        sb.push_back(3'b100);
        repeat (500) @(negedge clk);
        checks++;
        if (ds80 !== 1'b0) begin
            errors++;
            $display("FAIL debounce_early: ds80=%b expected 0", ds80);
        end
        repeat (600) @(negedge clk);
        wait_fs();
        checks++;
        if (ds80 !== 1'b1) begin
            errors++;
            $display("FAIL debounce_apply: ds80=%b expected 1", ds80);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
`ifdef VGA_MODE_CTRL_DEBOUNCE_EN
        test_debounce();
`else
        test_mode_change();
        test_cancel();
        test_timeout();
        test_settle_change();
        test_reset_mid();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pulse_missing: %0d expected mode_changed pulses not seen", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
